// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size and error encodings shared by dmem_bytelane and its lane aligner
package dmem_pkg;
  typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10} memSize_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL} errCode_e;
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store lane enables/steering and load extract/extend for sub-word access
module dmem_lane_align import dmem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OFF_W = 2
) (
  input  logic [1:0]          memSize,
  input  logic                memSigned,
  input  logic [OFF_W-1:0]    offset,
  input  logic [DATA_W-1:0]   memData,
  input  logic [DATA_W-1:0]   rdWord,
  output logic [DATA_W/8-1:0] wrEn,
  output logic [DATA_W-1:0]   wrWord,
  output logic [DATA_W-1:0]   ldData
);
  localparam int WB = DATA_W / 8;
  logic [DATA_W-1:0] shifted;
  // store data is replicated across lanes so the enables alone pick the target bytes
  always_comb begin
    shifted = rdWord >> {offset, 3'b000};
    wrEn = (memSize == SIZE_BYTE) ? WB'(1) << offset : (memSize == SIZE_HALF) ? WB'(3) << offset : '1;
    wrWord = (memSize == SIZE_BYTE) ? {WB{memData[7:0]}} : (memSize == SIZE_HALF) ? {(WB/2){memData[15:0]}} : memData;
    ldData = (memSize == SIZE_BYTE) ? {{(DATA_W-8){memSigned & shifted[7]}}, shifted[7:0]} :
             (memSize == SIZE_HALF) ? {{(DATA_W-16){memSigned & shifted[15]}}, shifted[15:0]} : rdWord;
  end
endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: MEM-stage data memory with registered loads, error strobe and saturating error count
// Byte/half access is built only with DMEM_SUBWORD_EN defined; otherwise the memory is word-only.
module dmem_bytelane import dmem_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    memAddr,
  input  logic [DATA_W-1:0]    memData,
  input  logic                 memReadFlag,
  input  logic                 memWriteFlag,
  input  logic [1:0]           memSize,
  input  logic                 memSigned,
  output logic [DATA_W-1:0]    data,
  output logic                 dataValid,
  output logic                 memError,
  output logic [1:0]           errCode,
  output logic [ERR_CNT_W-1:0] errCount
);
  localparam int WB = DATA_W / 8;
  localparam int OFF_W = log2(WB);
  localparam int IW = ADDR_W - OFF_W;
  localparam int AW = log2(DEPTH_WORDS);
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [OFF_W-1:0] offset;
  logic [IW-1:0] wordIdx;
  logic [WB-1:0] wrEn;
  logic [DATA_W-1:0] rdWord, wrWord, ldData;
  logic illegal, misalign, outRange, reject;
  logic [1:0] code;
  assign offset = memAddr[OFF_W-1:0];
  assign wordIdx = memAddr[ADDR_W-1:OFF_W];
  assign rdWord = mem[wordIdx[AW-1:0]];
`ifdef DMEM_SUBWORD_EN
  assign illegal = (memReadFlag & memWriteFlag) | (memSize == 2'b11);
  dmem_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) uAlign (
    .memSize(memSize),
    .memSigned(memSigned),
    .offset(offset),
    .memData(memData),
    .rdWord(rdWord),
    .wrEn(wrEn),
    .wrWord(wrWord),
    .ldData(ldData)
  );
`else
  logic unusedSigned;
  assign unusedSigned = memSigned;
  assign illegal = (memReadFlag & memWriteFlag) | (memSize != SIZE_WORD);
  assign wrEn = '1;
  assign wrWord = memData;
  assign ldData = rdWord;
`endif
  assign misalign = ((memSize == SIZE_HALF) & offset[0]) | ((memSize == SIZE_WORD) & (offset != '0));
  assign outRange = wordIdx >= IW'(DEPTH_WORDS);
  assign code = illegal ? ERR_ILLEGAL : misalign ? ERR_MISALIGN : outRange ? ERR_RANGE : ERR_NONE;
  assign reject = (memReadFlag | memWriteFlag) & (code != ERR_NONE);
  always_ff @(posedge clk)
    if (!reset && memWriteFlag && !reject)
      for (int i = 0; i < WB; i++) if (wrEn[i]) mem[wordIdx[AW-1:0]][i*8 +: 8] <= wrWord[i*8 +: 8];
  // a rejected load still answers, with zero data, so the pipeline sees one response per load
  always_ff @(posedge clk)
    if (reset) begin
      data <= '0;
      dataValid <= 1'b0;
      memError <= 1'b0;
      errCode <= ERR_NONE;
      errCount <= '0;
    end else begin
      data <= (memReadFlag & !reject) ? ldData : '0;
      dataValid <= memReadFlag;
      memError <= reject;
      errCode <= reject ? code : ERR_NONE;
      errCount <= (reject & (errCount != '1)) ? errCount + 1'b1 : errCount;
    end
endmodule
